// File: rtl/alu_op_sequencer.sv
// Sequences one op at a time into a multi-cycle ALU and returns result/flags via valid/ack.
// Optional watchdog on the ALU wait, enabled by defining ALU_TIMEOUT_EN.
module alu_op_sequencer #(
  parameter int DATA_W  = 16,
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OP_W-1:0]   op_code,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              op_setflags,
  output logic              ALU_start,
  output logic [OP_W-1:0]   ALU_op,
  output logic [DATA_W-1:0] ALU_a,
  output logic [DATA_W-1:0] ALU_b,
  input  logic              ALU_done,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [3:0]        ALU_flags,
  output logic              flags_we,
  output logic [3:0]        flags_data,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ack,
  output logic              busy,
  output logic              err
);

  // Counter is sized from TIMEOUT so it can always reach TIMEOUT-1 before saturating.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                alu_start_q, alu_start_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic                setflags_q, setflags_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                flags_we_q, flags_we_d;
  logic [3:0]          flags_data_q, flags_data_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                err_q, err_d;

`ifdef ALU_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      alu_start_q  <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      setflags_q   <= 1'b0;
      wait_cnt_q   <= '0;
      flags_we_q   <= 1'b0;
      flags_data_q <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_start_q  <= alu_start_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      setflags_q   <= setflags_d;
      wait_cnt_q   <= wait_cnt_d;
      flags_we_q   <= flags_we_d;
      flags_data_q <= flags_data_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    alu_start_d  = 1'b0;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    setflags_d   = setflags_q;
    wait_cnt_d   = wait_cnt_q;
    flags_we_d   = 1'b0;
    flags_data_d = flags_data_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          alu_op_d    = op_code;
          alu_a_d     = op_a;
          alu_b_d     = op_b;
          setflags_d  = op_setflags;
          alu_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
        // A done in the same cycle as the timeout still counts as normal completion.
        if (ALU_done) begin
          res_data_d   = ALU_result;
          flags_data_d = ALU_flags;
          flags_we_d   = setflags_q;
          res_valid_d  = 1'b1;
          err_d        = 1'b0;
          state_d      = RESP;
        end
`ifdef ALU_TIMEOUT_EN
        else if (wait_cnt_q == TO_LAST) begin
          res_data_d  = '0;
          res_valid_d = 1'b1;
          err_d       = 1'b1;
          state_d     = RESP;
        end
`endif
      end
      RESP: begin
        if (res_ack) begin
          res_valid_d = 1'b0;
          err_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign op_ready   = (state_q == IDLE) && !reset;
  assign busy       = (state_q != IDLE);
  assign ALU_start  = alu_start_q;
  assign ALU_op     = alu_op_q;
  assign ALU_a      = alu_a_q;
  assign ALU_b      = alu_b_q;
  assign flags_we   = flags_we_q;
  assign flags_data = flags_data_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed + randomized bench for alu_op_sequencer; the bench also plays the ALU.
module tb_alu_op_sequencer;
  localparam int DW = 16;
  localparam int OW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          op_valid, op_ready, op_setflags;
  logic [OW-1:0] op_code;
  logic [DW-1:0] op_a, op_b;
  logic          ALU_start, ALU_done;
  logic [OW-1:0] ALU_op;
  logic [DW-1:0] ALU_a, ALU_b, ALU_result;
  logic [3:0]    ALU_flags;
  logic          flags_we;
  logic [3:0]    flags_data;
  logic          res_valid, res_ack, busy, err;
  logic [DW-1:0] res_data;

  int passed = 0;
  int total  = 0;
  int start_total = 0;
  int fwe_total   = 0;
  logic [3:0] last_flags;

  alu_op_sequencer #(.DATA_W(DW), .OP_W(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_setflags(op_setflags),
    .ALU_start(ALU_start), .ALU_op(ALU_op), .ALU_a(ALU_a), .ALU_b(ALU_b),
    .ALU_done(ALU_done), .ALU_result(ALU_result), .ALU_flags(ALU_flags),
    .flags_we(flags_we), .flags_data(flags_data), .res_valid(res_valid),
    .res_data(res_data), .res_ack(res_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle so each high cycle counts once.
  always @(negedge clk) begin
    if (ALU_start) start_total++;
    if (flags_we)  fwe_total++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU: add for opcode 2, xor otherwise; flags {V,C,N,Z}.
  function automatic logic [DW+3:0] alu_ref(input logic [OW-1:0] c, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW:0] s;
    logic [DW-1:0] r;
    s = (c == 4'd2) ? ({1'b0, a} + {1'b0, b}) : {1'b0, a ^ b};
    r = s[DW-1:0];
    return {1'b0, s[DW], r[DW-1], (r == '0), r};
  endfunction

  // One full transaction. k = WAIT cycles before ALU_done; ack_d = RESP cycles before ack.
  task automatic do_op(input logic [OW-1:0] code, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic sf, input int k, input int ack_d, input logic spur);
    logic [DW+3:0] ref_v;
    logic to;
    int nwait, s0, f0;
    ref_v = alu_ref(code, a, b);
`ifdef ALU_TIMEOUT_EN
    to = (k >= TO);
`else
    to = 1'b0;
`endif
    nwait = to ? TO : k;
    s0 = start_total;
    f0 = fwe_total;
    check("idle_ready", op_ready, 1);
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b; op_setflags = sf;
    tick();
    check("start", ALU_start, 1);
    check("alu_op", ALU_op, code);
    check("alu_a", ALU_a, a);
    check("alu_b", ALU_b, b);
    check("busy_no_ready", op_ready, 0);
    // New op offered while busy, and possibly a spurious done in ISSUE.
    op_code = ~code; op_a = 16'($urandom); op_b = 16'($urandom); op_setflags = ~sf;
    ALU_done = spur; ALU_result = 16'hdead;
    tick();
    ALU_done = 1'b0;
    check("start_one_cycle", ALU_start, 0);
    check("no_early_res", res_valid, 0);
    for (int j = 0; j < nwait; j++) begin
      tick();
      if (j < nwait - 1 || !to) check("wait_no_res", res_valid, 0);
    end
    if (!to) begin
      ALU_done = 1'b1; ALU_result = ref_v[DW-1:0]; ALU_flags = ref_v[DW+3:DW];
      tick();
      ALU_done = 1'b0; ALU_result = 16'($urandom); ALU_flags = 4'($urandom);
      last_flags = ref_v[DW+3:DW];
    end
    check("res_valid", res_valid, 1);
    check("res_data", res_data, to ? 0 : ref_v[DW-1:0]);
    check("err", err, to);
    check("flags_we", flags_we, sf && !to);
    check("flags_data", flags_data, last_flags);
    check("op_stable", ALU_op, code);
    for (int i = 0; i < ack_d; i++) begin
      ALU_done = spur;
      tick();
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, to ? 0 : ref_v[DW-1:0]);
      check("we_once", flags_we, 0);
      check("resp_no_ready", op_ready, 0);
    end
    ALU_done = 1'b0;
    res_ack = 1'b1; op_valid = 1'b0;
    tick();
    res_ack = 1'b0;
    check("ack_clear", res_valid, 0);
    check("ack_err_clear", err, 0);
    check("ack_ready", op_ready, 1);
    check("ack_idle", busy, 0);
    check("a_stable", ALU_a, a);
    check("start_count", start_total - s0, 1);
    check("fwe_count", fwe_total - f0, (sf && !to) ? 1 : 0);
  endtask

  initial begin
    int f0;
    reset = 1'b1; op_valid = 1'b0; op_code = '0; op_a = '0; op_b = '0; op_setflags = 1'b0;
    ALU_done = 1'b0; ALU_result = '0; ALU_flags = '0; res_ack = 1'b0; last_flags = '0;
    tick(); tick();
    check("rst_ready", op_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_start", ALU_start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_flags_we", flags_we, 0);
    check("rst_err", err, 0);
    check("rst_regs", {ALU_op, ALU_a, ALU_b, flags_data} , 0);
    check("rst_res_data", res_data, 0);
    reset = 1'b0;
    tick();

    // Test-plan directed ops.
    do_op(4'd2, 16'h0005, 16'h0003, 1'b1, 1, 0, 1'b0);
    check("plan_flags", flags_data, 4'b0000);
    do_op(4'd1, 16'h00ff, 16'h00ff, 1'b0, 0, 1, 1'b0);
    do_op(4'd2, 16'hffff, 16'h0001, 1'b1, 2, 5, 1'b1);
    do_op(4'd3, 16'h1234, 16'h4321, 1'b1, 0, 0, 1'b1);

    // Reset in WAIT, then a late done.
    f0 = fwe_total;
    op_valid = 1'b1; op_code = 4'd2; op_a = 16'h1111; op_b = 16'h2222; op_setflags = 1'b1;
    tick();
    op_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("midrst_ready", op_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_op", ALU_op, 0);
    reset = 1'b0; ALU_done = 1'b1; ALU_result = 16'hbeef; ALU_flags = 4'hf;
    tick();
    ALU_done = 1'b0;
    last_flags = '0;
    check("late_done_idle", busy, 0);
    check("late_done_valid", res_valid, 0);
    check("late_done_we", flags_we, 0);
    check("late_done_ready", op_ready, 1);
    check("late_done_flags", flags_data, 0);
    check("late_done_fwe_count", fwe_total - f0, 0);

    // Timeout boundary: done on the last allowed WAIT cycle, then no done at all.
    do_op(4'd2, 16'h0100, 16'h0200, 1'b1, TO - 1, 1, 1'b0);
    do_op(4'd2, 16'h0300, 16'h0400, 1'b1, 20, 2, 1'b0);

    for (int n = 0; n < 20; n++)
      do_op(4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
            int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 1'($urandom));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequences one ALU operation at a time between the control unit and a multi-cycle ALU.
- Accepts an op via valid/ready, issues a single-cycle start to the ALU, waits for ALU_done, then returns the result via valid/ack.
- Generates the single-cycle write strobe (flags_we) and data (flags_data) that drive the flags register's ALU_ready/ALU_flags inputs. The flags register therefore updates exactly once per completed flag-setting op.

Parameters:
- DATA_W, 16, operand/result width
- OP_W, 4, ALU opcode width
- TIMEOUT, 64, max WAIT cycles before abort (used only with ALU_TIMEOUT_EN; legal range 2..65535)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  control unit presents an op
- op_ready  out  1  sequencer can accept an op
- op_code  in  OP_W  ALU opcode
- op_a  in  DATA_W  operand A
- op_b  in  DATA_W  operand B
- op_setflags  in  1  1 = commit ALU flags on completion
- ALU_start  out  1  one-cycle start pulse
- ALU_op  out  OP_W  registered opcode to ALU
- ALU_a  out  DATA_W  registered operand A
- ALU_b  out  DATA_W  registered operand B
- ALU_done  in  1  ALU result/flags valid this cycle
- ALU_result  in  DATA_W  ALU result
- ALU_flags  in  4  ALU flags {V,C,N,Z}
- flags_we  out  1  one-cycle strobe to flags register
- flags_data  out  4  flags to write, registered
- res_valid  out  1  result available
- res_data  out  DATA_W  registered result
- res_ack  in  1  consumer takes result
- busy  out  1  state != IDLE
- err  out  1  last op timed out (valid while res_valid)

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered except op_ready and busy, which decode state.
- Reset (sync; takes effect on the edge where reset=1):
  - state=IDLE.
  - ALU_start, flags_we, res_valid and err = 0.
  - ALU_op, ALU_a, ALU_b, flags_data, res_data = 0.
  - wait_cnt = 0.
  - op_ready=0 while reset=1.
- IDLE: op_ready=1. If op_valid=1 at edge n, latch op_code/op_a/op_b/op_setflags into ALU_op/ALU_a/ALU_b/setflags_q and go to ISSUE. op_valid=0 holds IDLE.
- ISSUE (cycle n+1): ALU_start=1 for exactly this cycle. ALU_done is ignored in this cycle. Next state is WAIT and wait_cnt=0.
- WAIT:
  - ALU_start=0; wait_cnt increments every cycle, saturating at its max.
  - On ALU_done=1: capture res_data<=ALU_result and flags_data<=ALU_flags; set flags_we<=setflags_q, res_valid<=1, err<=0; go to RESP.
  - Earliest response: ALU_done at n+2, res_valid/flags_we visible at n+3.
- RESP:
  - flags_we is high only in the first RESP cycle, then 0, even if res_ack is delayed.
  - res_valid and res_data hold until res_ack=1.
  - res_ack=1 (including in the first RESP cycle) clears res_valid and err next cycle and returns to IDLE. op_ready rises that same next cycle, so there is no back-to-back accept in RESP.
- ALU_operands stability: ALU_op, ALU_a and ALU_b are stable from ISSUE through the end of RESP. They change only on a new accept.
- Ignored ALU_done: ALU_done in IDLE, ISSUE or RESP is ignored, with no state change and no flags_we.
- Ignored inputs outside IDLE: op_valid is ignored in non-IDLE states; op_ready=0 there. res_ack outside RESP is ignored.
- Reset mid-operation: abort in any state. No flags_we is emitted for the aborted op, and a late ALU_done after reset is ignored (state IDLE).
- flags_we=0 for ops with op_setflags=0. flags_data is still updated, but the flags register ignores it.

Optional Feature:
- Macro ALU_TIMEOUT_EN.
- Defined: in WAIT, if ALU_done=0 and wait_cnt==TIMEOUT-1, go to RESP with res_valid=1, err=1, res_data=0, flags_we=0, flags_data unchanged. ALU_done in that same cycle wins over the timeout (normal completion, err=0).
- Undefined: WAIT is held indefinitely until ALU_done, err is constant 0, and TIMEOUT is unused.

Test Plan:
- Reset, then single op: op_code=2, A=0x0005, B=0x0003, setflags=1, ALU_done 2 cycles after start with result 0x0008 and flags 4'b0000. Expect ALU_start pulse exactly once, res_valid with res_data=0x0008, and flags_we=1 for exactly 1 cycle with flags_data=0000.
- setflags=0 op, ALU_flags=4'b0001. Expect res_valid=1 and flags_we never asserted.
- Delayed ack: hold res_ack=0 for 5 cycles. Expect res_valid and res_data stable for 5 cycles, flags_we high only the first cycle, op_ready=0 until the cycle after ack. Spurious ALU_done during RESP is ignored.
- Reset mid-WAIT with a pending op, then ALU_done=1 one cycle after reset releases. Expect state IDLE, flags_we=0, res_valid=0, op_ready=1.
- op_valid asserted while busy, plus ALU_done asserted in the ISSUE cycle. Expect no second accept and no completion until a later ALU_done in WAIT.
- ALU_TIMEOUT_EN with TIMEOUT=4 and ALU_done never asserted. Expect res_valid=1, err=1, res_data=0 at the 4th WAIT cycle edge, and flags_we=0.
